// File: rtl/imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : imem_fetch_sequencer
// Brief   : Shares the single instruction-memory port between the program
//           loader and core fetch, and sequences the PC.
// Revision: 1.0
// ============================================================================
module imem_fetch_sequencer #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              halt_req,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic [ADDR_W:0]   prog_len,
    output logic [1:0]        state,
    output logic              fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              fault_q, fault_d;

    logic              accept;
    logic [31:0]       prog_len_ext;

    // Loader is locked out while the core owns the port; reset also gates it.
    assign load_ready   = rst_n && (state_q != S_RUN);
    assign accept       = load_valid && load_ready;
    assign mem_we       = accept;
    assign mem_wdata    = load_data;
    assign instr        = mem_rdata;
    assign instr_valid  = rst_n && (state_q == S_RUN) && !stall && !halt_req;
    assign pc           = pc_q;
    assign prog_len     = prog_len_q;
    assign state        = state_q;
    assign fault        = fault_q;
    assign prog_len_ext = 32'(prog_len_q);

    // load_ptr is returned to 0 on load completion, so an IDLE/HALT accept
    // naturally writes address 0.
    always_comb begin
        mem_addr = pc_q[ADDR_W-1:0];
        if (state_q == S_LOAD || accept) begin
            mem_addr = load_ptr_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_ptr_d = load_ptr_q;
        prog_len_d = prog_len_q;
        fault_d    = fault_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (accept) begin
                    fault_d = 1'b0;
                    if (load_last || LAST_ADDR == '0) begin
                        prog_len_d = (ADDR_W+1)'(1);
                        load_ptr_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        prog_len_d = '0;
                        load_ptr_d = ADDR_ONE;
                        state_d    = S_LOAD;
                    end
                end else if (start && prog_len_q != '0) begin
                    pc_d    = '0;
                    fault_d = 1'b0;
                    state_d = S_RUN;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    if (load_last || load_ptr_q == LAST_ADDR) begin
                        prog_len_d = {1'b0, load_ptr_q} + (ADDR_W+1)'(1);
                        load_ptr_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        load_ptr_d = load_ptr_q + ADDR_ONE;
                    end
                end
            end

            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (branch_taken) begin
                    if (branch_target < prog_len_ext) begin
                        pc_d = branch_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                end else if (pc_q == prog_len_ext - 32'd1) begin
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            load_ptr_q <= '0;
            prog_len_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            load_ptr_q <= load_ptr_d;
            prog_len_q <= prog_len_d;
            fault_q    <= fault_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_fetch_sequencer
// Brief   : Directed self-checking bench with a behavioural instruction memory.
// Revision: 1.0
// ============================================================================
module tb_imem_fetch_sequencer;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid, load_last, load_ready;
    logic [31:0]       load_data;
    logic              start, halt_req, stall, branch_taken;
    logic [31:0]       branch_target;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata, mem_rdata, instr, pc;
    logic              instr_valid, fault;
    logic [ADDR_W:0]   prog_len;
    logic [1:0]        state;

    logic [31:0] mem [DEPTH];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    imem_fetch_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .start(start), .halt_req(halt_req),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .prog_len(prog_len), .state(state), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        rst_n = 1'b0; load_valid = 0; load_data = 0; load_last = 0;
        start = 0; halt_req = 0; stall = 0; branch_taken = 0; branch_target = 0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(load_ready), 32'd1);

        // 4-word load, load_valid held high
        for (int i = 0; i < 4; i++) begin
            load_valid = 1; load_data = 32'hA0 + i; load_last = (i == 3);
            #1;
            check($sformatf("ld4_we%0d", i), 32'(mem_we), 32'd1);
            check($sformatf("ld4_addr%0d", i), 32'(mem_addr), i);
            tick();
        end
        load_valid = 0; load_last = 0;
        check("ld4_len", 32'(prog_len), 32'd4);
        check("ld4_state", 32'(state), 32'd0);
        check("ld4_mem2", mem[2], 32'hA2);

        // Straight-line run to normal end
        start = 1; tick(); start = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("run_pc%0d", i), pc, i);
            check($sformatf("run_iv%0d", i), 32'(instr_valid), 32'd1);
            check($sformatf("run_instr%0d", i), instr, 32'hA0 + i);
            tick();
        end
        check("end_state", 32'(state), 32'd3);
        check("end_pc", pc, 32'd3);
        check("end_fault", 32'(fault), 32'd0);
        check("end_iv", 32'(instr_valid), 32'd0);

        // Stall then branch back to 0
        start = 1; tick(); start = 0;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_pc%0d", i), pc, 32'd1);
            check($sformatf("stall_iv%0d", i), 32'(instr_valid), 32'd0);
            tick();
        end
        stall = 0; branch_taken = 1; branch_target = 0;
        #1;
        check("br_pc_before", pc, 32'd1);
        tick();
        branch_taken = 0;
        check("br_pc_after", pc, 32'd0);
        check("br_state", 32'(state), 32'd2);

        // Out-of-range branch faults
        branch_taken = 1; branch_target = 9;
        tick();
        branch_taken = 0;
        check("oob_state", 32'(state), 32'd3);
        check("oob_fault", 32'(fault), 32'd1);
        check("oob_pc", pc, 32'd0);
        start = 1; tick(); start = 0;
        check("restart_state", 32'(state), 32'd2);
        check("restart_pc", pc, 32'd0);
        check("restart_fault", 32'(fault), 32'd0);

        // halt_req wins over stall and branch
        tick();
        halt_req = 1; stall = 1; branch_taken = 1; branch_target = 0;
        #1;
        check("hsb_iv", 32'(instr_valid), 32'd0);
        tick();
        halt_req = 0; stall = 0; branch_taken = 0;
        check("hsb_state", 32'(state), 32'd3);
        check("hsb_pc", pc, 32'd1);

        // Loader locked out during RUN
        start = 1; tick(); start = 0;
        load_valid = 1; load_data = 32'hDEAD; load_last = 1;
        #1;
        check("runld_ready", 32'(load_ready), 32'd0);
        check("runld_we", 32'(mem_we), 32'd0);
        tick();
        load_valid = 0; load_last = 0;
        check("runld_pc", pc, 32'd1);
        check("runld_mem0", mem[0], 32'hA0);

        // Asynchronous reset mid-RUN
        rst_n = 0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_pc", pc, 32'd0);
        check("arst_iv", 32'(instr_valid), 32'd0);
        check("arst_len", 32'(prog_len), 32'd0);
        #1 rst_n = 1;
        tick();

        // Full-depth load ends on the last address
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1; load_data = 32'hB00 + i; load_last = 0;
            #1;
            if (i == 0 || i == DEPTH - 1)
                check($sformatf("ld32_addr%0d", i), 32'(mem_addr), i);
            tick();
        end
        load_valid = 0;
        check("ld32_len", 32'(prog_len), 32'd32);
        check("ld32_state", 32'(state), 32'd0);
        check("ld32_mem31", mem[31], 32'hB1F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
